// File: rtl/axis_sched_pkg.sv
// Shared types and helpers for the AXI-Stream route scheduler.
package axis_sched_pkg;

  // Per-source ownership state.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } src_state_t;

  // Width of a source index: max(1, clog2(ports)).
  function automatic int src_width(input int ports);
    int w;
    w = $clog2(ports);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/axis_route_scheduler_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
  import axis_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [W-1:0] idx;

  // Scan from ptr upward; the first eligible index wins.
  always_comb begin
    winner = {W{1'b0}};
    found  = 1'b0;
    idx    = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end else begin
        // keep the earlier winner
      end
    end
  end

endmodule

// File: rtl/axis_route_scheduler.sv
// Route scheduler: grants source->destination routes one per cycle in
// round-robin order, holds them until the last beat or a watchdog expiry.
module axis_route_scheduler
  import axis_sched_pkg::*;
#(
  parameter int  PORTS       = 4,
  parameter int  TDEST_WIDTH = 8,
  parameter int  TMO_WIDTH   = 16,
  localparam int SRC_W       = src_width(PORTS)
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [PORTS-1:0]             req_valid,
  input  logic [PORTS*TDEST_WIDTH-1:0] req_dest,
  input  logic [PORTS-1:0]             m_ready,
  input  logic [PORTS-1:0]             beat_done,
  input  logic [PORTS-1:0]             beat_last,
  input  logic [TMO_WIDTH-1:0]         timeout_cycles,
  output logic [PORTS-1:0]             src_grant,
  output logic [PORTS-1:0]             route_valid,
  output logic [PORTS*SRC_W-1:0]       route_src,
  output logic [PORTS-1:0]             dest_err,
  output logic [PORTS-1:0]             timeout_err
);

  localparam int unsigned          PORTS_U = PORTS;
  localparam logic [TMO_WIDTH-1:0] CNT_MAX = {TMO_WIDTH{1'b1}};

  src_state_t             state   [PORTS];
  src_state_t             state_n [PORTS];
  logic [SRC_W-1:0]       dest_q  [PORTS];
  logic [SRC_W-1:0]       dest_n  [PORTS];
  logic [TMO_WIDTH-1:0]   cnt     [PORTS];
  logic [TMO_WIDTH-1:0]   cnt_n   [PORTS];
  logic [TDEST_WIDTH-1:0] req_d   [PORTS];
  logic [SRC_W-1:0]       ptr;
  logic [SRC_W-1:0]       ptr_n;
  logic [PORTS-1:0]       dest_ok;
  logic [PORTS-1:0]       eligible;
  logic [PORTS-1:0]       rel_last;
  logic [PORTS-1:0]       expire;
  logic [PORTS-1:0]       grant_n;
  logic [PORTS-1:0]       rv_n;
  logic [PORTS*SRC_W-1:0] rs_n;
  logic [SRC_W-1:0]       winner;
  logic                   found;

  // Decode requests, eligibility and release causes from current state.
  always_comb begin
    dest_err    = {PORTS{1'b0}};
    timeout_err = {PORTS{1'b0}};
    dest_ok     = {PORTS{1'b0}};
    eligible    = {PORTS{1'b0}};
    rel_last    = {PORTS{1'b0}};
    expire      = {PORTS{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      req_d[i]    = req_dest[i*TDEST_WIDTH +: TDEST_WIDTH];
      dest_ok[i]  = (32'(req_d[i]) < PORTS_U);
      dest_err[i] = req_valid[i] & ~dest_ok[i];
      // Ownership and tready are only meaningful for an in-range destination.
      eligible[i] = (state[i] == IDLE) & req_valid[i] & dest_ok[i]
                  & ~route_valid[req_d[i][SRC_W-1:0]]
                  & m_ready[req_d[i][SRC_W-1:0]];
      rel_last[i] = (state[i] == ACTIVE) & beat_done[i] & beat_last[i];
      expire[i]   = (state[i] == ACTIVE) & (timeout_cycles != {TMO_WIDTH{1'b0}})
                  & (cnt[i] == timeout_cycles);
      // A last beat coinciding with expiry is a normal release.
      timeout_err[i] = expire[i] & ~rel_last[i];
    end
  end

  rr_pick #(
    .N (PORTS),
    .W (SRC_W)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner),
    .found    (found)
  );

  // Next-state for per-source ownership, captured destination and watchdog.
  always_comb begin
    ptr_n = ptr;
    for (int i = 0; i < PORTS; i++) begin
      state_n[i] = state[i];
      dest_n[i]  = dest_q[i];
      cnt_n[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (found && (winner == SRC_W'(i))) begin
            state_n[i] = ACTIVE;
            dest_n[i]  = req_d[i][SRC_W-1:0];
            cnt_n[i]   = {TMO_WIDTH{1'b0}};
          end else begin
            cnt_n[i] = {TMO_WIDTH{1'b0}};
          end
        end
        ACTIVE: begin
          if (rel_last[i] || expire[i]) begin
            state_n[i] = IDLE;
            cnt_n[i]   = {TMO_WIDTH{1'b0}};
          end else if (beat_done[i]) begin
            cnt_n[i] = {TMO_WIDTH{1'b0}};
          end else if (cnt[i] == CNT_MAX) begin
            cnt_n[i] = cnt[i];
          end else begin
            cnt_n[i] = cnt[i] + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_n[i] = IDLE;
          cnt_n[i]   = {TMO_WIDTH{1'b0}};
        end
      endcase
    end
    if (found) begin
      ptr_n = (winner == SRC_W'(PORTS - 1)) ? {SRC_W{1'b0}} : (winner + SRC_W'(1));
    end else begin
      ptr_n = ptr;
    end
  end

  // Output images of the next state so the ports come straight from flops.
  always_comb begin
    grant_n = {PORTS{1'b0}};
    rv_n    = {PORTS{1'b0}};
    rs_n    = {(PORTS*SRC_W){1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      if (state_n[i] == ACTIVE) begin
        grant_n[i]                               = 1'b1;
        rv_n[dest_n[i]]                          = 1'b1;
        rs_n[int'(dest_n[i])*SRC_W +: SRC_W]     = SRC_W'(i);
      end else begin
        grant_n[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < PORTS; i++) begin
        state[i]  <= IDLE;
        dest_q[i] <= {SRC_W{1'b0}};
        cnt[i]    <= {TMO_WIDTH{1'b0}};
      end
      ptr         <= {SRC_W{1'b0}};
      src_grant   <= {PORTS{1'b0}};
      route_valid <= {PORTS{1'b0}};
      route_src   <= {(PORTS*SRC_W){1'b0}};
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        state[i]  <= state_n[i];
        dest_q[i] <= dest_n[i];
        cnt[i]    <= cnt_n[i];
      end
      ptr         <= ptr_n;
      src_grant   <= grant_n;
      route_valid <= rv_n;
      route_src   <= rs_n;
    end
  end

endmodule

// File: tb/tb_axis_route_scheduler.sv
// Scoreboard bench for axis_route_scheduler: directed scenarios followed by
// randomized traffic, all predicted by a route-ownership reference model.
module tb_axis_route_scheduler;

  localparam int P  = 4;
  localparam int TW = 8;
  localparam int MW = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            res;
  logic [P-1:0]    req_valid;
  logic [P*TW-1:0] req_dest;
  logic [P-1:0]    m_ready;
  logic [P-1:0]    beat_done;
  logic [P-1:0]    beat_last;
  logic [MW-1:0]   timeout_cycles;
  logic [P-1:0]    src_grant;
  logic [P-1:0]    route_valid;
  logic [P*SW-1:0] route_src;
  logic [P-1:0]    dest_err;
  logic [P-1:0]    timeout_err;

  always #5 clk = ~clk;

  axis_route_scheduler #(
    .PORTS       (P),
    .TDEST_WIDTH (TW),
    .TMO_WIDTH   (MW)
  ) dut (
    .clk            (clk),
    .res            (res),
    .req_valid      (req_valid),
    .req_dest       (req_dest),
    .m_ready        (m_ready),
    .beat_done      (beat_done),
    .beat_last      (beat_last),
    .timeout_cycles (timeout_cycles),
    .src_grant      (src_grant),
    .route_valid    (route_valid),
    .route_src      (route_src),
    .dest_err       (dest_err),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic [P-1:0]    derr;
    logic [P-1:0]    terr;
    logic [P-1:0]    grant;
    logic [P-1:0]    rv;
    logic [P*SW-1:0] rs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: which destination each source owns (-1 = none),
  // which source owns each destination, idle-cycle counts, rr pointer.
  int own_dest [P];
  int owner    [P];
  int cnt      [P];
  int ptr;
  int rdest    [P];
  int tmo_tab  [8] = '{0, 3, 7, 0, 15, 5, 0, 15};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < P; s++) begin
      own_dest[s] = -1;
      owner[s]    = -1;
      cnt[s]      = 0;
    end
    ptr = 0;
  endtask

  task automatic setd(input int s, input int d);
    rdest[s] = d;
    req_dest[s*TW +: TW] = TW'(d);
  endtask

  // Predict this cycle's outputs, advance the model by one edge, then clock.
  task automatic step();
    exp_t e;
    int   win, s, tmo, cmax;
    bit   last [P];
    bit   rel  [P];
    bit   act;
    tmo  = int'(timeout_cycles);
    cmax = (1 << MW) - 1;
    e.derr = '0; e.terr = '0; e.grant = '0; e.rv = '0; e.rs = '0;
    for (int i = 0; i < P; i++) begin
      act      = (own_dest[i] >= 0);
      e.derr[i]  = req_valid[i] && (rdest[i] >= P);
      e.grant[i] = act;
      e.rv[i]    = (owner[i] >= 0);
      if (owner[i] >= 0) e.rs[i*SW +: SW] = SW'(owner[i]);
      last[i]  = act && beat_done[i] && beat_last[i];
      rel[i]   = last[i] || (act && tmo != 0 && cnt[i] == tmo);
      e.terr[i]  = rel[i] && !last[i];
    end
    sb.push_back(e);
    if (res) begin
      model_reset();
    end else begin
      win = -1;
      for (int k = 0; k < P; k++) begin
        s = (ptr + k) % P;
        if (win < 0 && own_dest[s] < 0 && req_valid[s] && rdest[s] < P) begin
          if (owner[rdest[s]] < 0 && m_ready[rdest[s]]) win = s;
        end
      end
      for (int i = 0; i < P; i++) begin
        if (own_dest[i] >= 0) begin
          if (rel[i]) begin
            owner[own_dest[i]] = -1;
            own_dest[i] = -1;
            cnt[i] = 0;
          end else if (beat_done[i]) begin
            cnt[i] = 0;
          end else if (cnt[i] < cmax) begin
            cnt[i] = cnt[i] + 1;
          end
        end
      end
      if (win >= 0) begin
        own_dest[win]     = rdest[win];
        owner[rdest[win]] = win;
        cnt[win]          = 0;
        ptr               = (win + 1) % P;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    req_valid = '0; beat_done = '1; beat_last = '1;
    step();
    beat_done = '0; beat_last = '0;
    step();
  endtask

  // Monitor: compare DUT outputs with the oldest prediction, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("dest_err",    32'(dest_err),    32'(mon_e.derr));
        chk("timeout_err", 32'(timeout_err), 32'(mon_e.terr));
        chk("src_grant",   32'(src_grant),   32'(mon_e.grant));
        chk("route_valid", 32'(route_valid), 32'(mon_e.rv));
        chk("route_src",   32'(route_src),   32'(mon_e.rs));
      end
    end
  end

  initial begin
    res = 1'b1; req_valid = '0; req_dest = '0; m_ready = '1;
    beat_done = '0; beat_last = '0; timeout_cycles = '0;
    for (int s = 0; s < P; s++) rdest[s] = 0;
    model_reset();
    @(posedge clk);
    #2;
    step(); step();
    res = 1'b0;

    // Two sources contend for dest 1; src0 wins, src2 follows its last beat.
    setd(0, 1); setd(2, 1); req_valid = 4'b0101;
    step(); step();
    req_valid = 4'b0100; beat_done = 4'b0001; beat_last = 4'b0001;
    step();
    beat_done = '0; beat_last = '0;
    step(); step(); step();
    drain();

    // All four sources to distinct destinations: one grant per cycle.
    setd(0, 3); setd(1, 2); setd(2, 1); setd(3, 0); req_valid = 4'b1111;
    repeat (6) step();
    drain();

    // Invalid destination on src1 neither granted nor blocking src0.
    setd(1, 7); setd(0, 0); req_valid = 4'b0011;
    repeat (3) step();
    drain();

    // Watchdog expiry with no beats.
    timeout_cycles = 4'd5; setd(0, 0); req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (9) step();
    timeout_cycles = '0;

    // Destination not ready holds off the grant.
    m_ready = 4'b1011; setd(3, 2); req_valid = 4'b1000;
    repeat (3) step();
    m_ready = 4'b1111;
    repeat (3) step();
    drain();

    // Reset while two routes are up; requests regranted afterwards.
    setd(0, 0); setd(1, 1); req_valid = 4'b0011;
    repeat (3) step();
    res = 1'b1;
    step();
    res = 1'b0;
    repeat (4) step();
    drain();

    // Randomized traffic; later windows use rare beats to hit saturation.
    for (int n = 0; n < 1800; n++) begin
      res = ($urandom_range(0, 119) == 0);
      timeout_cycles = MW'(tmo_tab[(n / 150) % 8]);
      for (int s = 0; s < P; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          req_valid[s] = ($urandom_range(0, 2) != 0);
          setd(s, $urandom_range(0, 5));
        end
        m_ready[s]   = ($urandom_range(0, 4) != 0);
        beat_done[s] = ($urandom_range(0, (n >= 600) ? 15 : 1) == 0);
        beat_last[s] = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    res = 1'b0; req_valid = '0; beat_done = '0; beat_last = '0;
    step();
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_route_scheduler.md
AXIS_ROUTE_SCHEDULER -- requirements
Module: axis_route_scheduler

Interface
REQ-001 Parameter PORTS, default 4: number of source ports and number of destination ports.
REQ-002 Parameter TDEST_WIDTH, default 8: width of each destination field.
REQ-003 Parameter TMO_WIDTH, default 16: width of the watchdog counter and of the timeout threshold.
REQ-004 Local constant SRC_W = max(1, $clog2(PORTS)).
REQ-005 clk  in  1  single clock; all logic rises on posedge clk.
REQ-006 res  in  1  reset; synchronous, active-high.
REQ-007 req_valid  in  PORTS  per-source request: FIFO non-empty, packet pending.
REQ-008 req_dest  in  PORTS*TDEST_WIDTH  per-source destination of the head packet; source i occupies slice [i*TDEST_WIDTH +: TDEST_WIDTH].
REQ-009 m_ready  in  PORTS  per-destination tready.
REQ-010 beat_done  in  PORTS  per-source pulse: a beat was accepted (tvalid & tready) on that source's path.
REQ-011 beat_last  in  PORTS  per-source tlast qualifier for beat_done.
REQ-012 timeout_cycles  in  TMO_WIDTH  watchdog threshold; 0 disables the watchdog.
REQ-013 src_grant  out  PORTS  per-source level, high while that source owns a route.
REQ-014 route_valid  out  PORTS  per-destination level, high while that destination is owned.
REQ-015 route_src  out  PORTS*SRC_W  per-destination owning source index; 0 when route_valid is low.
REQ-016 dest_err  out  PORTS  per-source level, high while req_valid=1 and req_dest>=PORTS.
REQ-017 timeout_err  out  PORTS  per-source one-cycle pulse on watchdog release.

Function
REQ-018 Each source SHALL be in state IDLE or ACTIVE; IDLE->ACTIVE on grant, ACTIVE->IDLE on release.
REQ-019 A source SHALL be eligible only when all of the following hold: IDLE; req_valid=1; req_dest<PORTS; that destination not owned; m_ready of that destination =1.
REQ-020 At most one new grant SHALL be issued per cycle.
REQ-021 Grant selection SHALL be round-robin: search starts at pointer ptr; the first eligible index wins; ptr <= winner+1 mod PORTS; ptr holds when there is no winner.
REQ-022 Grant latency SHALL be 1 cycle: the outputs src_grant, route_valid and route_src update on the clock edge after the cycle in which the source is eligible.
REQ-023 req_dest SHALL be captured at grant; later changes while ACTIVE SHALL be ignored.
REQ-024 Release: beat_done & beat_last on an ACTIVE source SHALL clear src_grant, route_valid and route_src on the next edge.
REQ-025 A released source or destination SHALL NOT be regranted in the same cycle as its release; earliest regrant is visible 2 edges after the last beat.
REQ-026 beat_done on an IDLE source SHALL be ignored.
REQ-027 Watchdog: each ACTIVE source SHALL count cycles without beat_done, and the count SHALL reset to 0 on beat_done or on grant.
REQ-028 When the watchdog count equals timeout_cycles (nonzero), the scheduler SHALL release the route as in REQ-024 and pulse timeout_err for 1 cycle.
REQ-029 The watchdog counter SHALL saturate and never wrap.
REQ-030 If release and watchdog expiry coincide, the scheduler SHALL perform a normal release with no timeout_err.
REQ-031 A source with an invalid destination SHALL never be granted and SHALL NOT block other sources.
REQ-032 Multiple routes to distinct destinations SHALL be concurrent, up to PORTS routes.

Reset
REQ-033 While res=1, at each edge: all sources IDLE, ptr=0, counters=0, all outputs 0.
REQ-034 Reset asserted mid-packet SHALL drop all routes; the first grant is possible on the 2nd edge after res deasserts.

Structure
REQ-035 Package axis_sched_pkg SHALL hold the src_state_t enum {IDLE, ACTIVE} and the SRC_W helper function.
REQ-036 The design SHALL contain one combinational sub-module, rr_pick (inputs eligible and ptr; outputs winner index and found flag); all state SHALL remain in the top module.

Verification
REQ-037 Sources 0 and 2 request dest 1 in the same cycle, ptr=0: src0 granted at +1, route_src[1]=0; src0 last beat; src2 granted 2 edges later.
REQ-038 Four sources request dests 3,2,1,0 simultaneously: one grant per cycle in order 0,1,2,3, and all four routes are valid by cycle 4.
REQ-039 src1 requests dest 7 with PORTS=4: dest_err[1]=1, no grant; src0 requesting dest 0 is granted normally.
REQ-040 timeout_cycles=5, src0 granted, no beats: timeout_err[0] pulses 5 cycles after grant, and route_valid drops on the next edge.
REQ-041 m_ready[2]=0 while src3 requests dest 2: no grant; m_ready rises and the grant follows 1 edge later.
REQ-042 res pulses while 2 routes are active: all outputs 0; pending requests are regranted after reset is released.
